// File: rtl/tt_scoreboard.sv
// Table-tennis scoreboard: edge-detected point flags, win-by-margin FSM and a 4-digit
// multiplexed active-low 7-segment display. Define SERVE_IND_EN to build the serve indicator.
module tt_scoreboard #(
  parameter int unsigned WIN_PTS  = 11,
  parameter int unsigned MARGIN   = 2,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score_a,
  input  logic       score_b,
  input  logic       new_game,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       game_over,
  output logic       winner_a,
  output logic       winner_b,
  output logic       serve_a
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StPlay, StWonA, StWonB} state_e;

  state_e           state_q;
  logic             score_a_q, score_b_q;
  logic [6:0]       pts_a_q, pts_b_q;
  logic             game_over_q, winner_a_q, winner_b_q;
  logic [ScanW-1:0] scan_q;
  logic [1:0]       digit_q;
  logic [6:0]       wrap_q;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       clear;
  logic       pt_a, pt_b, only_a, only_b;
  logic [6:0] inc_a, inc_b;
  logic       win_a, win_b;

  assign clear  = reset | new_game;
  assign pt_a   = score_a & ~score_a_q;
  assign pt_b   = score_b & ~score_b_q;
  assign only_a = pt_a & ~pt_b;
  assign only_b = pt_b & ~pt_a;

  assign inc_a = (pts_a_q == 7'd99) ? pts_a_q : pts_a_q + 7'd1;
  assign inc_b = (pts_b_q == 7'd99) ? pts_b_q : pts_b_q + 7'd1;

  // A saturated counter takes no point, so it can never complete a win either.
  assign win_a = (pts_a_q != 7'd99) && (int'(inc_a) >= int'(WIN_PTS)) &&
                 (int'(inc_a) >= int'(pts_b_q) + int'(MARGIN));
  assign win_b = (pts_b_q != 7'd99) && (int'(inc_b) >= int'(WIN_PTS)) &&
                 (int'(inc_b) >= int'(pts_a_q) + int'(MARGIN));

  always_ff @(posedge clk) begin
    if (clear) begin
      score_a_q <= 1'b0;
      score_b_q <= 1'b0;
    end else begin
      score_a_q <= score_a;
      score_b_q <= score_b;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StPlay;
      pts_a_q     <= 7'd0;
      pts_b_q     <= 7'd0;
      game_over_q <= 1'b0;
      winner_a_q  <= 1'b0;
      winner_b_q  <= 1'b0;
    end else begin
      case (state_q)
        StPlay: begin
          if (only_a) begin
            pts_a_q <= inc_a;
            if (win_a) begin
              state_q     <= StWonA;
              game_over_q <= 1'b1;
              winner_a_q  <= 1'b1;
            end
          end else if (only_b) begin
            pts_b_q <= inc_b;
            if (win_b) begin
              state_q     <= StWonB;
              game_over_q <= 1'b1;
              winner_b_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign game_over = game_over_q;
  assign winner_a  = winner_a_q;
  assign winner_b  = winner_b_q;

`ifdef SERVE_IND_EN
  logic [6:0] nxt_a, nxt_b;
  logic [1:0] total_lo;
  logic       deuce;
  logic       serve_q;

  assign nxt_a    = (state_q == StPlay && only_a) ? inc_a : pts_a_q;
  assign nxt_b    = (state_q == StPlay && only_b) ? inc_b : pts_b_q;
  assign total_lo = nxt_a[1:0] + nxt_b[1:0];
  assign deuce    = (int'(nxt_a) >= int'(WIN_PTS) - 1) && (int'(nxt_b) >= int'(WIN_PTS) - 1);

  always_ff @(posedge clk) begin
    if (clear) begin
      serve_q <= 1'b1;
    end else if (state_q == StPlay) begin
      serve_q <= deuce ? ~total_lo[0] : ~total_lo[1];
    end
  end

  assign serve_a = serve_q;
`else
  assign serve_a = 1'b0;
`endif

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h90;
      default: seg_enc = 8'hFF;
    endcase
  endfunction

  logic [3:0] a_tens, a_units, b_tens, b_units;
  logic [3:0] digit_val;
  logic       digit_blank;

  assign a_tens  = 4'(pts_a_q / 7'd10);
  assign a_units = 4'(pts_a_q % 7'd10);
  assign b_tens  = 4'(pts_b_q / 7'd10);
  assign b_units = 4'(pts_b_q % 7'd10);

  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    case (digit_q)
      2'd0: digit_val = b_units;
      2'd1: begin
        digit_val   = b_tens;
        digit_blank = (b_tens == 4'd0);
      end
      2'd2: digit_val = a_units;
      default: begin
        digit_val   = a_tens;
        digit_blank = (a_tens == 4'd0);
      end
    endcase
    // digit_q[1] selects side A; loser always dark, winner blinks on wrap count bit 6.
    if (state_q == StWonA) begin
      digit_blank = digit_blank | ~digit_q[1] | ~wrap_q[6];
    end else if (state_q == StWonB) begin
      digit_blank = digit_blank | digit_q[1] | ~wrap_q[6];
    end
    seg_d = digit_blank ? 8'hFF
                        : (seg_enc(digit_val) & ((digit_q == 2'd2) ? 8'h7F : 8'hFF));
    an_d  = ~(4'b0001 << digit_q);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
      wrap_q  <= 7'd0;
      seg_q   <= 8'hC0;
      an_q    <= 4'b1110;
    end else begin
      if (scan_q == ScanMax) begin
        scan_q  <= '0;
        digit_q <= digit_q + 2'd1;
        wrap_q  <= wrap_q + 7'd1;
      end else begin
        scan_q <= scan_q + ScanW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_tt_scoreboard.sv
// Self-checking bench for tt_scoreboard: randomized and directed play checked against a
// point-level game model; the display is read back digit by digit and decoded expectations compared.
module tb_tt_scoreboard;

  localparam int ScanDiv = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0, score_a = 1'b0, score_b = 1'b0, new_game = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       game_over, winner_a, winner_b, serve_a;

  tt_scoreboard #(.WIN_PTS(11), .MARGIN(2), .SCAN_DIV(ScanDiv)) dut (
    .clk(clk), .reset(reset), .score_a(score_a), .score_b(score_b), .new_game(new_game),
    .seg(seg), .an(an), .game_over(game_over), .winner_a(winner_a), .winner_b(winner_b),
    .serve_a(serve_a)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int since_clr = 0;

  always @(posedge clk) begin
    if (reset | new_game) since_clr <= 0;
    else since_clr <= since_clr + 1;
  end

  // Game model: points, state (0 play, 1 A won, 2 B won), serve, last input levels.
  int  ma = 0, mb = 0, mst = 0;
  bit  mserve = 1'b1;
  bit  prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] enc_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic bit exp_serve();
`ifdef SERVE_IND_EN
    return mserve;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit sa, input bit sb, input bit clr);
    bit ea, eb;
    if (clr) begin
      ma = 0; mb = 0; mst = 0; mserve = 1'b1; prev_a = 1'b0; prev_b = 1'b0;
      return;
    end
    ea = sa && !prev_a;
    eb = sb && !prev_b;
    prev_a = sa;
    prev_b = sb;
    if (mst == 0 && ea != eb) begin
      if (ea && ma < 99) begin
        ma++;
        if (ma >= 11 && ma - mb >= 2) mst = 1;
      end else if (eb && mb < 99) begin
        mb++;
        if (mb >= 11 && mb - ma >= 2) mst = 2;
      end
      if (ma >= 10 && mb >= 10) mserve = ((ma + mb) % 2) == 0;
      else mserve = (((ma + mb) / 2) % 2) == 0;
    end
  endtask

  // Expected segments for digit idx observed k clocks after the last clear.
  function automatic logic [7:0] exp_seg(int idx, int k, int pa, int pb, int st);
    int  pts, val, wraps;
    bit  is_a, blank;
    is_a  = idx >= 2;
    pts   = is_a ? pa : pb;
    val   = (idx % 2 == 1) ? pts / 10 : pts % 10;
    blank = (idx % 2 == 1) && val == 0;
    if (st != 0) begin
      wraps = (k >= 1) ? (k - 1) / ScanDiv : 0;
      if (((st == 1) != is_a) || ((wraps / 64) % 2 == 0)) blank = 1'b1;
    end
    if (blank) return 8'hFF;
    return (idx == 2) ? (enc_tab[val] & 8'h7F) : enc_tab[val];
  endfunction

  task automatic step(input bit sa, input bit sb);
    score_a = sa;
    score_b = sb;
    @(posedge clk);
    model_edge(sa, sb, reset | new_game);
    #1;
  endtask

  task automatic point(input bit to_a);
    step(to_a, !to_a);
    step(1'b0, 1'b0);
  endtask

  task automatic clear_game();
    new_game = 1'b1;
    step(1'b0, 1'b0);
    new_game = 1'b0;
  endtask

  // Reads one seg value per digit, recording the clock count at which each was seen.
  task automatic capture(output logic [7:0] s[4], output int ks[4]);
    logic [3:0] want;
    bit found;
    for (int i = 0; i < 4; i++) begin
      want = 4'b0001 << i;
      want = ~want;
      found = 1'b0;
      s[i] = 8'h00;
      ks[i] = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        step(1'b0, 1'b0);
        if (an === want) begin
          found = 1'b1;
          s[i] = seg;
          ks[i] = since_clr;
        end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL capture digit%0d: an=%b never became %b", i, an, want);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s[4];
    int ks[4];
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h want C0", seg); end
    checks++;
    if ({game_over, winner_a, winner_b} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {game_over, winner_a, winner_b});
    end
    checks++;
    if (serve_a !== exp_serve()) begin
      errors++; $display("FAIL reset_serve: got %b want %b", serve_a, exp_serve());
    end
    for (int n = 0; n < 24; n++) begin
      logic [3:0] w;
      w = 4'b0001 << (((since_clr + 1 >= 1) ? (since_clr) / ScanDiv : 0) % 4);
      step(1'b0, 1'b0);
      checks++;
      if (an !== ~w) begin errors++; $display("FAIL scan_an k=%0d: got %b want %b", since_clr, an, ~w); end
    end
    capture(s, ks);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
        errors++; $display("FAIL reset_digit%0d: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
      end
    end
  endtask

  task automatic test_level_hold();
    logic [7:0] s[4];
    int ks[4];
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    capture(s, ks);
    checks++;
    if (s[2] !== 8'h79) begin errors++; $display("FAIL hold_digit2: got %h want 79", s[2]); end
    checks++;
    if (s[3] !== 8'hFF) begin errors++; $display("FAIL hold_digit3: got %h want FF", s[3]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
        errors++; $display("FAIL hold_digit%0d model: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] s[4];
    int ks[4];
    clear_game();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    capture(s, ks);
    checks++;
    if (s[2] !== 8'h40) begin errors++; $display("FAIL simul_digit2: got %h want 40", s[2]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
        errors++; $display("FAIL simul_digit%0d: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
      end
    end
  endtask

  task automatic test_straight_win();
    logic [7:0] s[4];
    int ks[4];
    clear_game();
    for (int p = 1; p <= 11; p++) begin
      step(1'b1, 1'b0);
      checks++;
      if (game_over !== (p == 11) || winner_a !== (p == 11)) begin
        errors++; $display("FAIL straight_win p=%0d: game_over=%b winner_a=%b want %b", p, game_over, winner_a, p == 11);
      end
      step(1'b0, 1'b0);
    end
    for (int n = 0; n < 3; n++) point(1'b0);
    checks++;
    if (winner_b !== 1'b0 || winner_a !== 1'b1) begin
      errors++; $display("FAIL won_ignores_b: winner_a=%b winner_b=%b want 1 0", winner_a, winner_b);
    end
    capture(s, ks);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
        errors++; $display("FAIL won_dark digit%0d: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
      end
    end
    while (since_clr < 4 * 64 * ScanDiv / 4 + 8) step(1'b0, 1'b0);
    capture(s, ks);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
        errors++; $display("FAIL won_lit digit%0d: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
      end
    end
  endtask

  task automatic test_new_game();
    bit want_srv [5];
`ifdef SERVE_IND_EN
    want_srv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    want_srv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    clear_game();
    checks++;
    if (game_over !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0) begin
      errors++; $display("FAIL new_game: game_over=%b an=%b seg=%h want 0 1110 C0", game_over, an, seg);
    end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (serve_a !== want_srv[p]) begin
        errors++; $display("FAIL serve_seq p=%0d: got %b want %b", p, serve_a, want_srv[p]);
      end
      point(p % 2 == 0);
    end
  endtask

  task automatic test_deuce();
    clear_game();
    for (int n = 0; n < 10; n++) begin
      point(1'b1);
      point(1'b0);
      checks++;
      if (serve_a !== exp_serve() || game_over !== 1'b0) begin
        errors++; $display("FAIL deuce_run %0d-%0d: serve=%b go=%b want %b 0", ma, mb, serve_a, game_over, exp_serve());
      end
    end
    for (int n = 0; n < 4; n++) begin
      point(n != 1);
      checks++;
      if (winner_a !== (n == 3) || game_over !== (n == 3) || serve_a !== exp_serve()) begin
        errors++; $display("FAIL deuce %0d-%0d: winner_a=%b go=%b serve=%b want %b %b %b", ma, mb,
                           winner_a, game_over, serve_a, n == 3, n == 3, exp_serve());
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] s[4];
    int ks[4];
    clear_game();
    for (int n = 0; n < 98; n++) begin
      point(1'b1);
      point(1'b0);
    end
    point(1'b1);
    point(1'b0);
    for (int n = 0; n < 3; n++) point(1'b1);
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL sat_game_over: got %b want 0", game_over); end
    capture(s, ks);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[i] !== ((i == 2) ? 8'h10 : 8'h90)) begin
        errors++; $display("FAIL sat_digit%0d: got %h want %h", i, s[i], (i == 2) ? 8'h10 : 8'h90);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] s[4];
    int ks[4];
    clear_game();
    for (int n = 0; n < 1500; n++) begin
      if (mst != 0 && $urandom_range(0, 7) == 0) begin
        new_game = 1'b1;
        step(1'b0, 1'b0);
        new_game = 1'b0;
      end else begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
      checks++;
      if (game_over !== (mst != 0) || winner_a !== (mst == 1) || winner_b !== (mst == 2) ||
          serve_a !== exp_serve()) begin
        errors++; $display("FAIL random n=%0d: go/wa/wb/srv=%b%b%b%b want %b%b%b%b", n, game_over,
                           winner_a, winner_b, serve_a, mst != 0, mst == 1, mst == 2, exp_serve());
      end
      if (n % 300 == 299) begin
        capture(s, ks);
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (s[i] !== exp_seg(i, ks[i], ma, mb, mst)) begin
            errors++; $display("FAIL random_digit%0d: got %h want %h", i, s[i], exp_seg(i, ks[i], ma, mb, mst));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_hold();
    test_simultaneous();
    test_straight_win();
    test_new_game();
    test_deuce();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
